// File: rtl/extensor_contador_if.sv
// Snapshot handshake between extensor_contador (slave) and its consumer (master).
// Carries the request/ack strobes plus the held snapshot and its overrun flag.
interface extensor_contador_if #(
  parameter int UPPER_W = 4
);
  logic               snap_req;
  logic               snap_ack;
  logic               snap_valid;
  logic               snap_ovr;
  logic [UPPER_W+3:0] snap_data;

  modport master (
    output snap_req,
    output snap_ack,
    input  snap_valid,
    input  snap_data,
    input  snap_ovr
  );

  modport slave (
    input  snap_req,
    input  snap_ack,
    output snap_valid,
    output snap_data,
    output snap_ovr
  );
endinterface

// File: rtl/extensor_contador.sv
// Extends a 4-bit mode counter with UPPER_W upper bits derived from its Q steps,
// plus a wrap pulse and a snapshot port. Optional Q step checker: STEP_CHECK_EN.
module extensor_contador #(
  parameter int UPPER_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic               enable,
  input  logic               cnt_reset,
  input  logic [UPPER_W-1:0] d_hi,
  input  logic [3:0]         d_lo,
  input  logic [3:0]         q_in,
  output logic [UPPER_W+3:0] count,
  output logic               wrap,
  output logic               step_err,
  extensor_contador_if.slave snap
);
  localparam logic [UPPER_W-1:0] UP_ONE = UPPER_W'(1);

  logic [1:0]         mode_d;
  logic               en_d;
  logic               rst_d;
  logic [UPPER_W-1:0] dhi_d;
  logic [3:0]         dlo_d;
  logic [3:0]         q_lo;
  logic [UPPER_W-1:0] upper;
  logic [UPPER_W-1:0] upper_next;
  logic               carry;
  logic               borrow;
  logic               wrap_next;
  logic [UPPER_W+3:0] count_next;

  // Controls seen at the previous edge explain the Q step observed now
  always_comb begin
    upper_next = upper;
    carry      = 1'b0;
    borrow     = 1'b0;
    if (rst_d) begin
      upper_next = '0;
    end else if (mode_d == 2'b11) begin
      upper_next = dhi_d;
    end else if ((mode_d == 2'b00 && en_d) || mode_d == 2'b10) begin
      if (q_in < q_lo) begin
        upper_next = upper + UP_ONE;
        carry      = 1'b1;
      end
    end else if (mode_d == 2'b01) begin
      if (q_in > q_lo) begin
        upper_next = upper - UP_ONE;
        borrow     = 1'b1;
      end
    end
  end

  assign wrap_next  = (carry && (upper == '1)) || (borrow && (upper == '0));
  assign count_next = {upper_next, q_in};
  assign count      = {upper, q_lo};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_d <= 2'b00;
      en_d   <= 1'b0;
      rst_d  <= 1'b0;
      dhi_d  <= '0;
      dlo_d  <= 4'd0;
      q_lo   <= 4'd0;
      upper  <= '0;
      wrap   <= 1'b0;
    end else begin
      mode_d <= mode;
      en_d   <= enable;
      rst_d  <= cnt_reset;
      dhi_d  <= d_hi;
      dlo_d  <= d_lo;
      q_lo   <= q_in;
      upper  <= upper_next;
      wrap   <= wrap_next;
    end
  end

  // Snapshot: a request while one is held is dropped and flagged; ack wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap.snap_valid <= 1'b0;
      snap.snap_data  <= '0;
      snap.snap_ovr   <= 1'b0;
    end else if (!snap.snap_valid) begin
      if (snap.snap_req) begin
        snap.snap_valid <= 1'b1;
        snap.snap_data  <= count_next;
      end
    end else begin
      if (snap.snap_req) snap.snap_ovr <= 1'b1;
      if (snap.snap_ack) snap.snap_valid <= 1'b0;
    end
  end

`ifdef STEP_CHECK_EN
  function automatic logic [3:0] predict_q(input logic       r,
                                           input logic [1:0] m,
                                           input logic       e,
                                           input logic [3:0] d,
                                           input logic [3:0] q);
    if (r) return 4'd0;
    case (m)
      2'b11:   return d;
      2'b01:   return q - 4'd1;
      2'b10:   return q + 4'd3;
      default: return e ? q + 4'd1 : q;
    endcase
  endfunction

  logic       chk_arm;
  logic [3:0] q_pred;

  assign q_pred = predict_q(rst_d, mode_d, en_d, dlo_d, q_lo);

  // chk_arm masks the first edge after reset, when the counter may not be in step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_arm  <= 1'b0;
      step_err <= 1'b0;
    end else begin
      chk_arm <= 1'b1;
      if (chk_arm && (q_in != q_pred)) step_err <= 1'b1;
    end
  end
`else
  logic unused_dlo;
  assign unused_dlo = ^dlo_d;
  assign step_err   = 1'b0;
`endif

endmodule

// File: tb/tb_extensor_contador.sv
// Bench for extensor_contador: drives a modelled 4-bit counter into q_in and
// compares every output against an arithmetic reference of the full count.
module tb_extensor_contador;
  localparam int UW  = 4;
  localparam int MOD = 1 << (UW + 4);
`ifdef STEP_CHECK_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic          enable;
  logic          cnt_reset;
  logic [UW-1:0] d_hi;
  logic [3:0]    d_lo;
  logic [3:0]    q_in;
  logic [UW+3:0] count;
  logic          wrap;
  logic          step_err;

  extensor_contador_if #(.UPPER_W(UW)) sif ();

  extensor_contador #(.UPPER_W(UW)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .enable    (enable),
    .cnt_reset (cnt_reset),
    .d_hi      (d_hi),
    .d_lo      (d_lo),
    .q_in      (q_in),
    .count     (count),
    .wrap      (wrap),
    .step_err  (step_err),
    .snap      (sif.slave)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int wrap_cnt    = 0;

  // Reference state: counter Q, full count, pending controls from the last edge
  logic [3:0]    q_cnt;
  logic [UW+3:0] ref_full;
  logic [UW+3:0] ref_sd;
  logic          ref_wrap, ref_sv, ref_ovr, ref_err;
  logic          armed, chk_cnt, force_en;
  logic [3:0]    force_val;
  logic          p_rst, p_en;
  logic [1:0]    p_mode;
  logic [UW-1:0] p_dhi;
  logic [3:0]    p_dlo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] cnt_next(input logic r, input logic [1:0] m, input logic e,
                                          input logic [3:0] d, input logic [3:0] q);
    if (r) return 4'd0;
    case (m)
      2'b11:   return d;
      2'b01:   return q - 4'd1;
      2'b10:   return q + 4'd3;
      default: return e ? q + 4'd1 : q;
    endcase
  endfunction

  task automatic tick();
    int cur, nxt, step;
    logic [3:0] qn;
    cur      = int'(ref_full);
    ref_wrap = 1'b0;
    if (p_rst) begin
      nxt = 0;
    end else if (p_mode == 2'b11) begin
      nxt = int'({p_dhi, p_dlo});
    end else if (p_mode == 2'b01) begin
      ref_wrap = (cur == 0);
      nxt      = (cur + MOD - 1) % MOD;
    end else begin
      step     = (p_mode == 2'b10) ? 3 : (p_en ? 1 : 0);
      ref_wrap = (cur + step) >= MOD;
      nxt      = (cur + step) % MOD;
    end
    ref_full = nxt[UW+3:0];
    if (CHK_ON && armed && (q_in !== ref_full[3:0])) ref_err = 1'b1;
    if (!ref_sv) begin
      if (sif.snap_req) begin
        ref_sv = 1'b1;
        ref_sd = ref_full;
      end
    end else begin
      if (sif.snap_req) ref_ovr = 1'b1;
      if (sif.snap_ack) ref_sv = 1'b0;
    end
    qn     = cnt_next(cnt_reset, mode, enable, d_lo, q_cnt);
    p_rst  = cnt_reset;
    p_mode = mode;
    p_en   = enable;
    p_dhi  = d_hi;
    p_dlo  = d_lo;
    @(posedge clk);
    #1;
    q_cnt = qn;
    q_in  = force_en ? force_val : q_cnt;
    armed = 1'b1;
    if (wrap === 1'b1) wrap_cnt++;
    if (chk_cnt) begin
      chk("count", 32'(count), 32'(ref_full));
      chk("wrap", 32'(wrap), 32'(ref_wrap));
      chk("snap_data", 32'(sif.snap_data), 32'(ref_sd));
    end
    chk("snap_valid", 32'(sif.snap_valid), 32'(ref_sv));
    chk("snap_ovr", 32'(sif.snap_ovr), 32'(ref_ovr));
    chk("step_err", 32'(step_err), 32'(ref_err));
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    mode          = 2'b00;
    enable        = 1'b0;
    cnt_reset     = 1'b0;
    d_hi          = '0;
    d_lo          = 4'd0;
    sif.snap_req  = 1'b0;
    sif.snap_ack  = 1'b0;
    q_cnt         = 4'd0;
    q_in          = 4'd0;
    ref_full      = '0;
    ref_sd        = '0;
    ref_wrap      = 1'b0;
    ref_sv        = 1'b0;
    ref_ovr       = 1'b0;
    ref_err       = 1'b0;
    armed         = 1'b0;
    chk_cnt       = 1'b1;
    force_en      = 1'b0;
    force_val     = 4'd0;
    p_rst         = 1'b0;
    p_mode        = 2'b00;
    p_en          = 1'b0;
    p_dhi         = '0;
    p_dlo         = 4'd0;
    @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_snap_valid", 32'(sif.snap_valid), 32'd0);
    chk("rst_snap_data", 32'(sif.snap_data), 32'd0);
    chk("rst_snap_ovr", 32'(sif.snap_ovr), 32'd0);
    chk("rst_step_err", 32'(step_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // Count up 300 clocks: one wrap at 0xFF -> 0x00, ends at 299 mod 256
    do_reset();
    mode     = 2'b00;
    enable   = 1'b1;
    wrap_cnt = 0;
    repeat (300) tick();
    chk("t1_wraps", 32'(wrap_cnt), 32'd1);
    chk("t1_count", 32'(count), 32'h2B);

    // Step by 3 across the Q boundary: 0x2D -> 0x30 without wrap
    mode = 2'b11; d_hi = 4'h2; d_lo = 4'hD;
    tick();
    mode = 2'b10;
    tick();
    chk("t2_load", 32'(count), 32'h2D);
    mode = 2'b00; enable = 1'b0;
    tick();
    chk("t2_count", 32'(count), 32'h30);
    chk("t2_wrap", 32'(wrap), 32'd0);

    // Count down from zero: borrow wraps to 0xFF, then 0xFE
    cnt_reset = 1'b1;
    tick();
    cnt_reset = 1'b0;
    tick();
    chk("t3_zero", 32'(count), 32'h00);
    mode = 2'b01;
    tick();
    tick();
    chk("t3_count_ff", 32'(count), 32'hFF);
    chk("t3_wrap", 32'(wrap), 32'd1);
    mode = 2'b00; enable = 1'b0;
    tick();
    chk("t3_count_fe", 32'(count), 32'hFE);
    chk("t3_wrap_off", 32'(wrap), 32'd0);

    // Parallel load and counter reset
    mode = 2'b11; d_hi = 4'h5; d_lo = 4'h9;
    tick();
    mode = 2'b00; enable = 1'b0;
    tick();
    chk("t4_load", 32'(count), 32'h59);
    chk("t4_wrap", 32'(wrap), 32'd0);
    cnt_reset = 1'b1;
    tick();
    cnt_reset = 1'b0;
    tick();
    chk("t4_clear", 32'(count), 32'h00);

    // Randomized controls and handshake against the reference
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cnt_reset    = ($urandom_range(15) == 0);
      mode         = 2'($urandom_range(3));
      enable       = 1'($urandom_range(1));
      d_hi         = 4'($urandom_range(15));
      d_lo         = 4'($urandom_range(15));
      sif.snap_req = ($urandom_range(3) == 0);
      sif.snap_ack = ($urandom_range(3) == 0);
      tick();
    end
    sif.snap_req = 1'b0;
    sif.snap_ack = 1'b1;
    tick();
    sif.snap_ack = 1'b0;

    // Snapshot held through counting, overrun, then ack
    do_reset();
    mode = 2'b11; d_hi = 4'h4; d_lo = 4'h2;
    tick();
    mode = 2'b00; enable = 1'b0;
    tick();
    chk("t5_count", 32'(count), 32'h42);
    sif.snap_req = 1'b1;
    tick();
    sif.snap_req = 1'b0;
    enable = 1'b1;
    repeat (5) tick();
    sif.snap_req = 1'b1;
    tick();
    sif.snap_req = 1'b0;
    chk("t5_data", 32'(sif.snap_data), 32'h42);
    chk("t5_ovr", 32'(sif.snap_ovr), 32'd1);
    chk("t5_valid_held", 32'(sif.snap_valid), 32'd1);
    sif.snap_ack = 1'b1;
    tick();
    sif.snap_ack = 1'b0;
    chk("t5_valid_ack", 32'(sif.snap_valid), 32'd0);
    sif.snap_req = 1'b1;
    tick();
    sif.snap_req = 1'b0;
    reset = 1'b1;
    #2;
    chk("t5_async_valid", 32'(sif.snap_valid), 32'd0);
    chk("t5_async_count", 32'(count), 32'd0);

    // Counter Q forced off its predicted step
    do_reset();
    mode = 2'b00; enable = 1'b1;
    repeat (5) tick();
    force_en  = 1'b1;
    force_val = 4'h7;
    tick();
    chk_cnt  = 1'b0;
    force_en = 1'b0;
    tick();
    chk("t6_err", 32'(step_err), 32'(CHK_ON));
    mode = 2'b00; enable = 1'b0;
    repeat (4) tick();
    chk("t6_err_sticky", 32'(step_err), 32'(CHK_ON));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
